// File: rtl/tpu_gemm_array.sv
// Output-stationary int8 GEMM tile: C = (A + input_offset) x B over a
// ARRAY_DIM x ARRAY_DIM PE array. Operands are streamed from single-port A/B
// buffers and packed int32 rows are written to the C buffer.
// Build option: define TPU_ACC_SAT_EN for sticky saturating accumulation;
// otherwise each accumulate wraps modulo 2^ACC_W.
module tpu_gemm_array #(
    parameter int unsigned ARRAY_DIM = 4,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned OFFSET_W  = 9,
    parameter int unsigned K_W       = 11,
    parameter int unsigned M_W       = 12,
    parameter int unsigned N_W       = 9,
    parameter int unsigned A_IDX_W   = 19,
    parameter int unsigned B_IDX_W   = 18,
    parameter int unsigned C_IDX_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [K_W-1:0]           K,
    input  logic [M_W-1:0]           M,
    input  logic [N_W-1:0]           N,
    input  logic [31:0]              input_offset,
    output logic                     busy,
    output logic                     done,
    output logic                     A_wr_en,
    output logic [A_IDX_W-1:0]       A_index,
    output logic [8*ARRAY_DIM-1:0]   A_data_in,
    input  logic [8*ARRAY_DIM-1:0]   A_data_out,
    output logic                     B_wr_en,
    output logic [B_IDX_W-1:0]       B_index,
    output logic [8*ARRAY_DIM-1:0]   B_data_in,
    input  logic [8*ARRAY_DIM-1:0]   B_data_out,
    output logic                     C_wr_en,
    output logic [C_IDX_W-1:0]       C_index,
    output logic [32*ARRAY_DIM-1:0]  C_data_in,
    input  logic [32*ARRAY_DIM-1:0]  C_data_out
);

    localparam int unsigned P      = ARRAY_DIM;
    localparam int unsigned AW     = 8 * P;
    localparam int unsigned CW     = 32 * P;
    localparam int unsigned SUM_W  = OFFSET_W + 1;
    localparam int unsigned PROD_W = OFFSET_W + 8;
    localparam int unsigned R_W    = (P > 1) ? $clog2(P) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    logic [2:0]                  state, state_d;
    logic [K_W-1:0]              k_lat, k_lat_d, k_cnt, k_cnt_d;
    logic [M_W-1:0]              m_lat, m_lat_d;
    logic [N_W-1:0]              n_lat, n_lat_d;
    logic signed [OFFSET_W-1:0]  off_lat, off_lat_d;
    logic [1:0]                  drn_cnt, drn_cnt_d;
    logic [R_W-1:0]              r_cnt, r_cnt_d, row_sel;
    logic [M_W:0]                a_row, a_row_d;
    logic [N_W:0]                b_col, b_col_d;
    logic [A_IDX_W-1:0]          a_base, a_base_d, A_index_d;
    logic [B_IDX_W-1:0]          b_base, b_base_d, B_index_d;
    logic [C_IDX_W-1:0]          c_base, c_base_d, C_index_d;
    logic                        busy_d, done_d, C_wr_en_d, pe_clr;
    logic [CW-1:0]               C_data_in_d, row_data_c;
    logic                        last_a, last_b;

    logic                        dat_vld, prod_vld;
    logic signed [7:0]           a_lane_c [P];
    logic signed [7:0]           b_lane_c [P];
    logic signed [SUM_W-1:0]     sum_c    [P];
    logic signed [PROD_W-1:0]    prod_c   [P][P];
    logic signed [PROD_W-1:0]    prod     [P][P];
    logic signed [ACC_W-1:0]     pe       [P][P];
    logic signed [ACC_W-1:0]     acc_c    [P][P];
`ifdef TPU_ACC_SAT_EN
    logic signed [ACC_W:0]       wide_c   [P][P];
    logic                        sat      [P][P];
    logic                        sat_c    [P][P];
`endif

    logic unused_ok;
    assign unused_ok = ^{C_data_out, input_offset[31:OFFSET_W]};

    assign A_wr_en   = 1'b0;
    assign B_wr_en   = 1'b0;
    assign A_data_in = '0;
    assign B_data_in = '0;

    // Tile-walk end conditions: this block row/column reaches M/N.
    assign last_a = ({1'b0, m_lat} <= (a_row + (M_W+1)'(P)));
    assign last_b = ({1'b0, n_lat} <= (b_col + (N_W+1)'(P)));

    // Row of PE accumulators presented to C, sign-extended per 32-bit lane.
    always_comb begin
        row_sel = (state == S_WRITE) ? R_W'(r_cnt + R_W'(1)) : '0;
        row_data_c = '0;
        for (int j = 0; j < int'(P); j++) begin
            row_data_c[CW-1-32*j -: 32] = 32'(pe[row_sel][j]);
        end
    end

    // Next-state and registered-output computation for the tile sequencer.
    always_comb begin
        state_d     = state;
        k_lat_d     = k_lat;
        m_lat_d     = m_lat;
        n_lat_d     = n_lat;
        off_lat_d   = off_lat;
        k_cnt_d     = k_cnt;
        drn_cnt_d   = drn_cnt;
        r_cnt_d     = r_cnt;
        a_row_d     = a_row;
        b_col_d     = b_col;
        a_base_d    = a_base;
        b_base_d    = b_base;
        c_base_d    = c_base;
        A_index_d   = A_index;
        B_index_d   = B_index;
        C_index_d   = C_index;
        C_data_in_d = C_data_in;
        busy_d      = busy;
        done_d      = 1'b0;
        C_wr_en_d   = 1'b0;
        pe_clr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (K == '0 || M == '0 || N == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_LOAD;
                        busy_d    = 1'b1;
                        k_lat_d   = K;
                        m_lat_d   = M;
                        n_lat_d   = N;
                        off_lat_d = input_offset[OFFSET_W-1:0];
                        k_cnt_d   = '0;
                        a_row_d   = '0;
                        b_col_d   = '0;
                        a_base_d  = '0;
                        b_base_d  = '0;
                        c_base_d  = '0;
                        A_index_d = '0;
                        B_index_d = '0;
                    end
                end
            end
            S_LOAD: begin
                if (k_cnt == k_lat - K_W'(1)) begin
                    state_d   = S_DRAIN;
                    drn_cnt_d = '0;
                end else begin
                    k_cnt_d   = k_cnt + K_W'(1);
                    A_index_d = A_index + A_IDX_W'(1);
                    B_index_d = B_index + B_IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (drn_cnt == 2'd2) begin
                    state_d     = S_WRITE;
                    r_cnt_d     = '0;
                    C_wr_en_d   = 1'b1;
                    C_index_d   = c_base;
                    C_data_in_d = row_data_c;
                end else begin
                    drn_cnt_d = drn_cnt + 2'd1;
                end
            end
            S_WRITE: begin
                if (r_cnt == R_W'(P - 1)) begin
                    pe_clr   = 1'b1;
                    c_base_d = c_base + C_IDX_W'(P);
                    if (last_a && last_b) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_NEXT;
                        if (last_a) begin
                            a_row_d  = '0;
                            a_base_d = '0;
                            b_col_d  = b_col + (N_W+1)'(P);
                            b_base_d = b_base + B_IDX_W'(k_lat);
                        end else begin
                            a_row_d  = a_row + (M_W+1)'(P);
                            a_base_d = a_base + A_IDX_W'(k_lat);
                        end
                    end
                end else begin
                    r_cnt_d     = r_cnt + R_W'(1);
                    C_wr_en_d   = 1'b1;
                    C_index_d   = C_index + C_IDX_W'(1);
                    C_data_in_d = row_data_c;
                end
            end
            S_NEXT: begin
                state_d   = S_LOAD;
                k_cnt_d   = '0;
                A_index_d = a_base;
                B_index_d = b_base;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k_lat     <= '0;
            m_lat     <= '0;
            n_lat     <= '0;
            off_lat   <= '0;
            k_cnt     <= '0;
            drn_cnt   <= '0;
            r_cnt     <= '0;
            a_row     <= '0;
            b_col     <= '0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            A_index   <= '0;
            B_index   <= '0;
            C_index   <= '0;
            C_data_in <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            C_wr_en   <= 1'b0;
        end else begin
            state     <= state_d;
            k_lat     <= k_lat_d;
            m_lat     <= m_lat_d;
            n_lat     <= n_lat_d;
            off_lat   <= off_lat_d;
            k_cnt     <= k_cnt_d;
            drn_cnt   <= drn_cnt_d;
            r_cnt     <= r_cnt_d;
            a_row     <= a_row_d;
            b_col     <= b_col_d;
            a_base    <= a_base_d;
            b_base    <= b_base_d;
            c_base    <= c_base_d;
            A_index   <= A_index_d;
            B_index   <= B_index_d;
            C_index   <= C_index_d;
            C_data_in <= C_data_in_d;
            busy      <= busy_d;
            done      <= done_d;
            C_wr_en   <= C_wr_en_d;
        end
    end

    // Lane unpack, offset add and signed multiply feeding the product register.
    always_comb begin
        for (int i = 0; i < int'(P); i++) begin
            a_lane_c[i] = A_data_out[AW-1-8*i -: 8];
            b_lane_c[i] = B_data_out[AW-1-8*i -: 8];
            sum_c[i]    = SUM_W'(a_lane_c[i]) + SUM_W'(off_lat);
        end
        for (int i = 0; i < int'(P); i++) begin
            for (int j = 0; j < int'(P); j++) begin
                prod_c[i][j] = PROD_W'(sum_c[i]) * PROD_W'(b_lane_c[j]);
            end
        end
    end

    // Accumulate step: wrapping, or clamped with a sticky per-PE flag.
    always_comb begin
        for (int i = 0; i < int'(P); i++) begin
            for (int j = 0; j < int'(P); j++) begin
`ifdef TPU_ACC_SAT_EN
                wide_c[i][j] = (ACC_W+1)'(pe[i][j]) + (ACC_W+1)'(prod[i][j]);
                sat_c[i][j]  = sat[i][j];
                acc_c[i][j]  = ACC_W'(wide_c[i][j]);
                if (sat[i][j]) begin
                    acc_c[i][j] = pe[i][j];
                end else if (wide_c[i][j][ACC_W] != wide_c[i][j][ACC_W-1]) begin
                    sat_c[i][j] = 1'b1;
                    acc_c[i][j] = wide_c[i][j][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                      : {1'b0, {(ACC_W-1){1'b1}}};
                end
`else
                acc_c[i][j] = pe[i][j] + ACC_W'(prod[i][j]);
`endif
            end
        end
    end

    // Operand pipeline and PE accumulators; cleared after each tile's last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_vld  <= 1'b0;
            prod_vld <= 1'b0;
            for (int i = 0; i < int'(P); i++) begin
                for (int j = 0; j < int'(P); j++) begin
                    prod[i][j] <= '0;
                    pe[i][j]   <= '0;
`ifdef TPU_ACC_SAT_EN
                    sat[i][j]  <= 1'b0;
`endif
                end
            end
        end else begin
            dat_vld  <= (state == S_LOAD);
            prod_vld <= dat_vld;
            for (int i = 0; i < int'(P); i++) begin
                for (int j = 0; j < int'(P); j++) begin
                    prod[i][j] <= prod_c[i][j];
                    if (pe_clr) begin
                        pe[i][j]  <= '0;
`ifdef TPU_ACC_SAT_EN
                        sat[i][j] <= 1'b0;
`endif
                    end else if (prod_vld) begin
                        pe[i][j]  <= acc_c[i][j];
`ifdef TPU_ACC_SAT_EN
                        sat[i][j] <= sat_c[i][j];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tpu_gemm_array.sv
// Scoreboard bench for tpu_gemm_array (ARRAY_DIM=4, ACC_W=20).
module tb_tpu_gemm_array;

    localparam int MEM = 64;
    localparam longint ACC_MAX = 524287;
    localparam longint ACC_MIN = -524288;
    localparam longint ACC_MOD = 1048576;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid;
    logic [10:0]   K;
    logic [11:0]   M;
    logic [8:0]    N;
    logic [31:0]   input_offset;
    logic          busy, done;
    logic          A_wr_en, B_wr_en, C_wr_en;
    logic [18:0]   A_index;
    logic [17:0]   B_index;
    logic [15:0]   C_index;
    logic [31:0]   A_data_in, A_data_out, B_data_in, B_data_out;
    logic [127:0]  C_data_in, C_data_out;

    logic [31:0]   A_mem [MEM];
    logic [31:0]   B_mem [MEM];
    logic [15:0]   exp_idx  [$];
    logic [127:0]  exp_data [$];
    int            total = 0;
    int            bad   = 0;

    tpu_gemm_array #(.ARRAY_DIM(4), .ACC_W(20)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .K(K), .M(M), .N(N),
        .input_offset(input_offset), .busy(busy), .done(done),
        .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in), .A_data_out(A_data_out),
        .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in), .B_data_out(B_data_out),
        .C_wr_en(C_wr_en), .C_index(C_index), .C_data_in(C_data_in), .C_data_out(C_data_out)
    );

    // One-cycle-latency read ports of the A and B buffers.
    always @(posedge clk) begin
        A_data_out <= A_mem[A_index[5:0]];
        B_data_out <= B_mem[B_index[5:0]];
    end

    function automatic logic [31:0] model_lane(input int a, input int b, input int r,
                                               input int j, input int k, input logic [31:0] off);
        longint acc = 0;
        bit sat = 0;
        logic [31:0] wa, wb;
        byte av, bv;
        logic signed [8:0] o9;
        longint prod;
        o9 = off[8:0];
        for (int kk = 0; kk < k; kk++) begin
            wa = A_mem[(a * k + kk) % MEM];
            wb = B_mem[(b * k + kk) % MEM];
            av = wa[31-8*r -: 8];
            bv = wb[31-8*j -: 8];
            prod = (longint'(av) + longint'(o9)) * longint'(bv);
`ifdef TPU_ACC_SAT_EN
            if (!sat) begin
                acc += prod;
                if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1; end
                else if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1; end
            end
`else
            acc = (acc + prod) % ACC_MOD;
            if (acc > ACC_MAX) acc -= ACC_MOD;
            if (acc < ACC_MIN) acc += ACC_MOD;
`endif
        end
        return 32'(acc);
    endfunction

    task automatic push_job(input int k, input int m, input int n, input logic [31:0] off);
        int mb, nb;
        logic [127:0] row;
        mb = (m + 3) / 4;
        nb = (n + 3) / 4;
        for (int b = 0; b < nb; b++)
            for (int a = 0; a < mb; a++)
                for (int r = 0; r < 4; r++) begin
                    for (int j = 0; j < 4; j++) row[127-32*j -: 32] = model_lane(a, b, r, j, k, off);
                    exp_idx.push_back(16'(b * mb * 4 + a * 4 + r));
                    exp_data.push_back(row);
                end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < MEM; i++) begin
            A_mem[i] = $urandom;
            B_mem[i] = $urandom;
        end
    endtask

    task automatic start_job(input int k, input int m, input int n, input logic [31:0] off);
        @(negedge clk);
        K = 11'(k); M = 12'(m); N = 9'(n); input_offset = off;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pop/compare writes until done; then check latency, completeness and pulse width.
    task automatic wait_done(input string name, input int budget, input bit expect_writes);
        int n = 0, last_wr = -10, done_at = 0;
        bit got_done = 0;
        logic [15:0] ei;
        logic [127:0] ed;
        while (n < budget) begin
            if (C_wr_en === 1'b1) begin
                total++;
                if (exp_idx.size() == 0) begin
                    bad++;
                    $display("FAIL %s unexpected write idx=%0d want=none", name, C_index);
                end else begin
                    ei = exp_idx.pop_front();
                    ed = exp_data.pop_front();
                    if (C_index !== ei || C_data_in !== ed) begin
                        bad++;
                        $display("FAIL %s write got idx=%0d data=%h want idx=%0d data=%h",
                                 name, C_index, C_data_in, ei, ed);
                    end
                end
                last_wr = n;
            end
            if (done === 1'b1) begin
                got_done = 1;
                done_at = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL %s done timeout got=0 want=1", name);
        end else if (expect_writes) begin
            total++;
            if (done_at != last_wr + 1) begin
                bad++;
                $display("FAIL %s done latency got=%0d want=%0d", name, done_at - last_wr, 1);
            end
        end
        total++;
        if (exp_idx.size() != 0) begin
            bad++;
            $display("FAIL %s missing writes got=%0d want=0", name, exp_idx.size());
        end
        exp_idx.delete();
        exp_data.delete();
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done pulse width got=%b want=0", name, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; K = '0; M = '0; N = '0; input_offset = '0; C_data_out = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done); end
        total++; if (C_wr_en !== 1'b0) begin bad++; $display("FAIL reset wr_en got=%b want=0", C_wr_en); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        fill_rand();
        A_mem[0] = 32'h01020304;
        B_mem[0] = 32'h01010101;
        for (int r = 0; r < 4; r++) begin
            exp_idx.push_back(16'(r));
            exp_data.push_back({4{32'(r + 1)}});
        end
        start_job(1, 4, 4, 32'd0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic busy got=%b want=1", busy); end
        wait_done("basic", 100, 1);
    endtask

    task automatic test_offset_cancel();
        fill_rand();
        for (int i = 0; i < 3; i++) A_mem[i] = 32'h80808080;
        for (int r = 0; r < 4; r++) begin
            exp_idx.push_back(16'(r));
            exp_data.push_back(128'd0);
        end
        start_job(3, 4, 4, 32'd128);
        wait_done("offset_cancel", 100, 1);
    endtask

    task automatic test_multi_tile();
        fill_rand();
        push_job(2, 5, 6, 32'hFFFF_FFFD);
        start_job(2, 5, 6, 32'hFFFF_FFFD);
        wait_done("multi_tile", 400, 1);
    endtask

    task automatic test_saturation();
        logic [31:0] lane;
`ifdef TPU_ACC_SAT_EN
        lane = 32'd524287;
`else
        lane = 32'hFFF8_2496;
`endif
        for (int i = 0; i < 11; i++) begin
            A_mem[i] = 32'h7F7F7F7F;
            B_mem[i] = 32'h7F7F7F7F;
        end
        for (int r = 0; r < 4; r++) begin
            exp_idx.push_back(16'(r));
            exp_data.push_back({4{lane}});
        end
        start_job(11, 4, 4, 32'd255);
        wait_done("saturation", 100, 1);
    endtask

    task automatic test_ignore();
        fill_rand();
        push_job(2, 4, 4, 32'd5);
        start_job(2, 4, 4, 32'd5);
        K = 11'd3; M = 12'd8; N = 9'd8;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        wait_done("ignore_busy", 100, 1);
    endtask

    task automatic test_zero_dim();
        start_job(0, 4, 4, 32'd0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL k_zero busy got=%b want=0", busy); end
        wait_done("k_zero", 10, 0);
        start_job(3, 4, 0, 32'd0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL n_zero busy got=%b want=0", busy); end
        wait_done("n_zero", 10, 0);
    endtask

    task automatic test_reset_mid();
        int n = 0, extra = 0;
        logic [15:0] ei;
        logic [127:0] ed;
        fill_rand();
        push_job(4, 8, 4, 32'd7);
        start_job(4, 8, 4, 32'd7);
        while (!(busy === 1'b1 && A_index == 19'd4) && n < 200) begin
            if (C_wr_en === 1'b1 && exp_idx.size() != 0) begin
                ei = exp_idx.pop_front();
                ed = exp_data.pop_front();
                total++;
                if (C_index !== ei || C_data_in !== ed) begin
                    bad++;
                    $display("FAIL reset_mid tile0 got idx=%0d data=%h want idx=%0d data=%h",
                             C_index, C_data_in, ei, ed);
                end
            end
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin bad++; $display("FAIL reset_mid tile1 timeout got=%0d want<200", n); end
        rst = 1'b1;
        exp_idx.delete();
        exp_data.delete();
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid busy got=%b want=0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (C_wr_en === 1'b1 || done === 1'b1) extra++;
            @(negedge clk);
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL reset_mid activity got=%0d want=0", extra); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset_cancel();
        test_multi_tile();
        test_saturation();
        test_ignore();
        test_zero_dim();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
